// File: rtl/lcd_nibble_writer_if.sv
// Processor-to-LCD write handshake plus the 4-bit character LCD bus it drives.
interface lcd_nibble_writer_if;
  logic       write_Enabled;
  logic [7:0] iData;
  logic       ready;
  logic       oIsInitialized;
  logic [3:0] oLCD_Data;
  logic       oLCD_Enabled;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       oLCD_StrataFlashControl;

  modport master (
    output write_Enabled, iData,
    input  ready, oIsInitialized, oLCD_Data, oLCD_Enabled, oLCD_RS, oLCD_RW,
           oLCD_StrataFlashControl
  );

  modport slave (
    input  write_Enabled, iData,
    output ready, oIsInitialized, oLCD_Data, oLCD_Enabled, oLCD_RS, oLCD_RW,
           oLCD_StrataFlashControl
  );
endinterface

// File: rtl/lcd_nibble_writer.sv
// Responder that owns LCD power-on init and writes accepted bytes as two
// nibbles on the 4-bit LCD bus; every wait shares one down-counter.
module lcd_nibble_writer #(
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_40US    = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_E       = 12,
  parameter int unsigned T_NIBGAP  = 50
) (
  input logic          Clock,
  input logic          Reset,
  lcd_nibble_writer_if.slave bus
);

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_POWERON, T_INIT1), max_u(T_INIT2, T_40US)),
                                        max_u(max_u(T_CLEAR, T_SETUP), max_u(T_E, T_NIBGAP)));
  localparam int CW = $clog2(T_MAX + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [2:0] {POWER_WAIT, INIT_NIB, CFG, IDLE, WRITE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

  state_t     state;
  phase_t     phase;
  logic [2:0] step;
  cnt_t       cnt;
  logic [7:0] latched;
  logic [3:0] lcd_data;
  logic       lcd_e;
  logic       lcd_rs;
  logic       ready_q;
  logic       init_done;

  function automatic logic [7:0] cfg_byte(logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Wait that follows nibble `st` of the current sequence; even steps of a
  // byte are upper nibbles and are followed by the inter-nibble gap.
  function automatic cnt_t item_wait(state_t s, logic [2:0] st);
    cnt_t w;
    w = cnt_t'(T_40US);
    case (s)
      INIT_NIB: begin
        if (st == 3'd0)      w = cnt_t'(T_INIT1);
        else if (st == 3'd1) w = cnt_t'(T_INIT2);
      end
      CFG: begin
        if (!st[0])          w = cnt_t'(T_NIBGAP);
        else if (st == 3'd7) w = cnt_t'(T_CLEAR);
      end
      default: begin
        if (!st[0])          w = cnt_t'(T_NIBGAP);
      end
    endcase
    return w;
  endfunction

  function automatic logic [3:0] nib_of(state_t s, logic [2:0] st, logic [7:0] b);
    logic [7:0] byte_v;
    case (s)
      INIT_NIB: byte_v = (st == 3'd3) ? 8'h22 : 8'h33;
      CFG:      byte_v = cfg_byte(st[2:1]);
      default:  byte_v = b;
    endcase
    return st[0] ? byte_v[3:0] : byte_v[7:4];
  endfunction

  function automatic logic [2:0] last_step(state_t s);
    case (s)
      INIT_NIB: return 3'd3;
      CFG:      return 3'd7;
      default:  return 3'd1;
    endcase
  endfunction

  // The counter holds the cycles left in the current phase, including the
  // present one; zero only occurs right after reset, in POWER_WAIT.
  // NOTE: state and outputs use non-blocking assignments so every branch
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= POWER_WAIT;
      phase     <= PH_SETUP;
      step      <= '0;
      cnt       <= '0;
      latched   <= '0;
      lcd_data  <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      ready_q   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        POWER_WAIT: begin
          if (cnt == '0) begin
            cnt <= cnt_t'(T_POWERON - 1);
          end else if (cnt == cnt_t'(1)) begin
            state    <= INIT_NIB;
            step     <= '0;
            phase    <= PH_SETUP;
            cnt      <= cnt_t'(T_SETUP);
            lcd_data <= nib_of(INIT_NIB, 3'd0, latched);
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        INIT_NIB, CFG, WRITE: begin
          if (cnt != cnt_t'(1)) begin
            cnt <= cnt - cnt_t'(1);
          end else begin
            case (phase)
              PH_SETUP: begin
                phase <= PH_PULSE;
                lcd_e <= 1'b1;
                cnt   <= cnt_t'(T_E);
              end
              PH_PULSE: begin
                phase <= PH_HOLD;
                lcd_e <= 1'b0;
                cnt   <= cnt_t'(1);
              end
              PH_HOLD: begin
                phase <= PH_WAIT;
                cnt   <= item_wait(state, step);
              end
              default: begin
                if (step == last_step(state)) begin
                  if (state == INIT_NIB) begin
                    state    <= CFG;
                    step     <= '0;
                    phase    <= PH_SETUP;
                    cnt      <= cnt_t'(T_SETUP);
                    lcd_data <= nib_of(CFG, 3'd0, latched);
                  end else begin
                    state     <= IDLE;
                    ready_q   <= 1'b1;
                    init_done <= 1'b1;
                  end
                end else begin
                  step     <= step + 3'd1;
                  phase    <= PH_SETUP;
                  cnt      <= cnt_t'(T_SETUP);
                  lcd_data <= nib_of(state, step + 3'd1, latched);
                end
              end
            endcase
          end
        end

        IDLE: begin
          if (bus.write_Enabled) begin
            latched  <= bus.iData;
            state    <= WRITE;
            step     <= '0;
            phase    <= PH_SETUP;
            cnt      <= cnt_t'(T_SETUP);
            lcd_data <= bus.iData[7:4];
            lcd_rs   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end

        default: state <= POWER_WAIT;
      endcase
    end
  end

  assign bus.oLCD_Data               = lcd_data;
  assign bus.oLCD_Enabled            = lcd_e;
  assign bus.oLCD_RS                 = lcd_rs;
  assign bus.oLCD_RW                 = 1'b0;
  assign bus.oLCD_StrataFlashControl = 1'b1;
  assign bus.oIsInitialized          = init_done;
  assign bus.ready                   = ready_q;

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

- Responder end of the processor-to-LCD write interface.
- The processor core raises `write_Enabled` with a character byte on `iData`. This block accepts the byte and drives the 4-bit character LCD bus on the starter board (`SF_D`, `LCD_E`, `LCD_RS`, `LCD_RW`, StrataFlash disable).
- It owns the LCD power-on initialization and reports completion on `oIsInitialized`. The core holds its fetch while `ready` is low.

## Interface
Parameters (cycle counts at 50 MHz):
- T_POWERON, 750000, power-on wait before first nibble (15 ms)
- T_INIT1, 205000, wait after first 0x3 nibble (4.1 ms)
- T_INIT2, 5000, wait after second 0x3 nibble (100 us)
- T_40US, 2000, command/data settle wait (40 us)
- T_CLEAR, 82000, wait after Clear Display (1.64 ms)
- T_SETUP, 2, RS/data setup before E rises
- T_E, 12, E high width
- T_NIBGAP, 50, gap between upper and lower nibble of a byte (1 us)

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- write_Enabled  in  1  write request; sampled only while `ready`=1
- iData  in  8  character byte; captured at acceptance
- oLCD_Data  out  4  LCD nibble bus (SF_D[3:0])
- oLCD_Enabled  out  1  LCD E strobe
- oLCD_RS  out  1  0 = command, 1 = data
- oLCD_RW  out  1  constant 0 (write only)
- oLCD_StrataFlashControl  out  1  constant 1 (flash disabled)
- oIsInitialized  out  1  power-on init sequence complete
- ready  out  1  idle and able to accept a byte

## Operation
- Reset values, applied immediately and asynchronously:
  - oLCD_Data=0, oLCD_Enabled=0, oLCD_RS=0, oLCD_RW=0
  - oLCD_StrataFlashControl=1, oIsInitialized=0, ready=0
  - FSM in POWER_WAIT with its counter cleared.
- Nibble primitive NIB(n, rs), length T_SETUP+T_E+1 cycles:
  - SETUP: data=n, RS=rs, E=0 for T_SETUP cycles.
  - PULSE: E=1 for T_E cycles.
  - HOLD: E=0 for 1 cycle, data and RS unchanged.
- Byte primitive BYTE(b, rs, w): NIB(b[7:4]), then wait T_NIBGAP, then NIB(b[3:0]), then wait w.
- FSM: POWER_WAIT → INIT_NIB → CFG → IDLE ⇄ WRITE. A single down-counter is shared by all waits.
- POWER_WAIT: counts T_POWERON cycles.
- INIT_NIB, all with RS=0:
  - NIB(3) then wait T_INIT1
  - NIB(3) then wait T_INIT2
  - NIB(3) then wait T_40US
  - NIB(2) then wait T_40US
- CFG, all with RS=0:
  - BYTE(0x28, w=T_40US)
  - BYTE(0x06, w=T_40US)
  - BYTE(0x0C, w=T_40US)
  - BYTE(0x01, w=T_CLEAR)
- IDLE: `ready`=1. After the first entry, oIsInitialized=1 and stays 1 until Reset.
- Acceptance: a rising edge with ready=1 and write_Enabled=1 latches iData. FSM goes to WRITE and `ready`=0 from the next cycle.
- WRITE: performs BYTE(latched, rs=1, w=T_40US), then returns to IDLE.
- write_Enabled is level-sensitive. If it is still high when `ready` returns, the current iData is accepted as a new byte on that edge. Back-to-back writes are therefore legal.
- write_Enabled while ready=0 (init or WRITE) is ignored and never queued.
- iData changes after acceptance do not affect the byte in flight.
- Reset asserted mid-init or mid-write: outputs return to reset values at once and the sequence restarts from POWER_WAIT.

## Timing
- Let N = T_SETUP+T_E+1.
- `ready` low window per byte: exactly T_BYTE = 2N+T_NIBGAP+T_40US cycles. This is 2080 cycles at defaults.
- The first SETUP cycle of the upper nibble is the cycle after the acceptance edge.
- Init duration, from the first edge after Reset release to ready=1:
  - T_POWERON + 4N + T_INIT1 + T_INIT2 + 2·T_40US
  - + 4·(2N+T_NIBGAP) + 3·T_40US + T_CLEAR
- oIsInitialized and `ready` rise on the same edge.
- No E pulse occurs before T_POWERON cycles have elapsed.
- E never rises in the same cycle that data/RS change.
- All outputs are registered; no combinational input→output path.

## Test plan
Sim parameters: T_POWERON=100, T_INIT1=40, T_INIT2=10, T_40US=8, T_CLEAR=20, T_E=3, T_SETUP=1, T_NIBGAP=2. This gives N=5 and T_BYTE=20.
- Release Reset, write_Enabled=0:
  - E pulses carry nibbles 3,3,3,2,2,8,0,6,0,C,0,1, all with RS=0.
  - First E rise occurs after cycle 100.
  - oIsInitialized and ready rise at cycle 278.
  - Every E pulse is 3 cycles wide.
- After init, pulse write_Enabled for 1 cycle with iData=0x41:
  - Nibbles 4 then 1, RS=1, 2-cycle gap between them.
  - ready low exactly 20 cycles, then back to 1.
- Hold write_Enabled=1 with iData=0x48; change iData to 0x69 during busy:
  - First byte on the bus is 0x48.
  - On ready's return, 0x69 is accepted on that same edge.
- write_Enabled=1, iData=0x55 throughout init:
  - No RS=1 pulse before cycle 278.
  - The first data byte, 0x55, starts right after ready rises.
- Assert Reset during the lower nibble of a write:
  - E, RS and data go to 0 and ready/oIsInitialized go to 0 in the same cycle, asynchronously.
  - After release, full init replays and completes at 278.
- Throughout all scenarios: oLCD_RW==0 and oLCD_StrataFlashControl==1.
